// File: rtl/sa_stream_pkg.sv
// Shared stream-packing definitions for the systolic-array input/output path.
// Provides the pack ratio and beat-index width as functions of the stream
// widths, the beat-index type used while accumulating narrow beats, and a
// helper that tests whether a TKEEP vector has every valid byte enabled.
package sa_stream_pkg;

  // Upper bounds for the package-level types; they cover every supported configuration.
  localparam int unsigned BEAT_IDX_MAX_W = 8;
  localparam int unsigned KEEP_MAX_W     = 64;

  // Index of the next lane to fill while accumulating (ACCUM state).
  typedef logic [BEAT_IDX_MAX_W-1:0] beat_idx_t;

  function automatic int unsigned pack_ratio(input int unsigned in_w,
                                             input int unsigned out_w);
    return out_w / in_w;
  endfunction

  function automatic int unsigned beat_idx_width(input int unsigned in_w,
                                                 input int unsigned out_w);
    int unsigned r;
    r = pack_ratio(in_w, out_w);
    return (r <= 2) ? 1 : $clog2(r);
  endfunction

  // True when the low n_bytes bits of keep are all set.
  function automatic logic keep_all_ones(input logic [KEEP_MAX_W-1:0] keep,
                                         input int unsigned           n_bytes);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < KEEP_MAX_W; i++) begin
      if ((i < n_bytes) && !keep[i]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Registered AXI-Stream output slice.
// Holds one word (data/keep/last) with its valid flag and keeps it stable while
// the consumer applies backpressure. A new word may be loaded whenever the slice
// is empty or its current word is leaving in the same cycle (full throughput).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   load, load_*            write strobe and the word to capture
//   can_load                slice can accept a word this cycle
//   m_tdata/m_tkeep/m_tlast registered output word
//   m_tvalid, m_tready      output handshake
module axis_out_reg #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              load_last,
  output logic              can_load,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [KEEP_W-1:0] keep_q,  keep_d;
  logic              last_q,  last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      keep_d  = load_keep;
      last_d  = load_last;
    end else if (m_tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign can_load = !valid_q || m_tready;
  assign m_tvalid = valid_q;
  assign m_tdata  = data_q;
  assign m_tkeep  = keep_q;
  assign m_tlast  = last_q;

endmodule

// File: rtl/axis_input_packer.sv
// Narrow-to-wide AXI-Stream packer feeding the systolic-array top.
// Collects RATIO = outDataWidth/inDataWidth input beats (first beat in the LSBs)
// into one output word; TLAST flushes a short word with unused lanes zeroed.
// Output goes through a registered slice with full-throughput handshake.
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   S_AXIS_*                narrow input stream from the DMA
//   M_AXIS_*                wide packed stream to the array top
//   wordCount, packetCount  words / TLAST words accepted downstream (wrapping)
//   keepError               sticky: a non-last beat arrived with partial TKEEP
module axis_input_packer
  import sa_stream_pkg::*;
#(
  parameter int unsigned inDataWidth  = 64,
  parameter int unsigned outDataWidth = 128,
  parameter int unsigned countWidth   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [inDataWidth-1:0]    S_AXIS_TDATA,
  input  logic [inDataWidth/8-1:0]  S_AXIS_TKEEP,
  input  logic                      S_AXIS_TLAST,
  input  logic                      S_AXIS_TVALID,
  output logic                      S_AXIS_TREADY,
  output logic [outDataWidth-1:0]   M_AXIS_TDATA,
  output logic [outDataWidth/8-1:0] M_AXIS_TKEEP,
  output logic                      M_AXIS_TLAST,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic [countWidth-1:0]     wordCount,
  output logic [countWidth-1:0]     packetCount,
  output logic                      keepError
);

  localparam int unsigned RATIO      = pack_ratio(inDataWidth, outDataWidth);
  localparam int unsigned IN_KEEP_W  = inDataWidth / 8;
  localparam int unsigned OUT_KEEP_W = outDataWidth / 8;

  // Reset assertion is asynchronous; release is retimed through two flops so
  // all internal state leaves reset on the same clock edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       int_rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= rst_sync_d;
  end

  assign int_rst_n = rst_sync_q[1];

  beat_idx_t                 beat_idx_q, beat_idx_d;
  logic [outDataWidth-1:0]   asm_data_q, asm_data_d;
  logic [OUT_KEEP_W-1:0]     asm_keep_q, asm_keep_d;
  logic                      keep_err_q, keep_err_d;
  logic [countWidth-1:0]     word_cnt_q, word_cnt_d;
  logic [countWidth-1:0]     pkt_cnt_q,  pkt_cnt_d;

  logic                      in_fire;
  logic                      out_fire;
  logic                      completing;
  logic                      can_load;
  logic                      out_load;
  logic [outDataWidth-1:0]   merged_data;
  logic [OUT_KEEP_W-1:0]     merged_keep;

  // Ready is gated until internal reset has released so no beat is taken
  // while the assembly state is still held clear.
  assign S_AXIS_TREADY = int_rst_n && can_load;
  assign in_fire       = S_AXIS_TVALID && S_AXIS_TREADY;
  assign out_fire      = M_AXIS_TVALID && M_AXIS_TREADY;
  assign completing    = (beat_idx_q == beat_idx_t'(RATIO - 1)) || S_AXIS_TLAST;

  // Assembly contents with the current beat dropped into lane beat_idx_q;
  // lanes above it are forced empty so a flushed short word carries no junk.
  always_comb begin
    merged_data = asm_data_q;
    merged_keep = asm_keep_q;
    for (int unsigned lane = 0; lane < RATIO; lane++) begin
      if (beat_idx_t'(lane) == beat_idx_q) begin
        merged_data[lane*inDataWidth +: inDataWidth] = S_AXIS_TDATA;
        merged_keep[lane*IN_KEEP_W +: IN_KEEP_W]     = S_AXIS_TKEEP;
      end else if (beat_idx_t'(lane) > beat_idx_q) begin
        merged_data[lane*inDataWidth +: inDataWidth] = '0;
        merged_keep[lane*IN_KEEP_W +: IN_KEEP_W]     = '0;
      end
    end
  end

  always_comb begin
    beat_idx_d = beat_idx_q;
    asm_data_d = asm_data_q;
    asm_keep_d = asm_keep_q;
    keep_err_d = keep_err_q;
    word_cnt_d = word_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    out_load   = 1'b0;

    if (in_fire) begin
      if (!S_AXIS_TLAST &&
          !keep_all_ones(KEEP_MAX_W'(S_AXIS_TKEEP), IN_KEEP_W)) begin
        keep_err_d = 1'b1;
      end
      if (completing) begin
        out_load   = 1'b1;
        beat_idx_d = '0;
        asm_data_d = '0;
        asm_keep_d = '0;
      end else begin
        beat_idx_d = beat_idx_q + beat_idx_t'(1);
        asm_data_d = merged_data;
        asm_keep_d = merged_keep;
      end
    end

    if (out_fire) begin
      word_cnt_d = word_cnt_q + 1'b1;
      if (M_AXIS_TLAST) pkt_cnt_d = pkt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge int_rst_n) begin
    if (!int_rst_n) begin
      beat_idx_q <= '0;
      asm_data_q <= '0;
      asm_keep_q <= '0;
      keep_err_q <= 1'b0;
      word_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      beat_idx_q <= beat_idx_d;
      asm_data_q <= asm_data_d;
      asm_keep_q <= asm_keep_d;
      keep_err_q <= keep_err_d;
      word_cnt_q <= word_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  axis_out_reg #(
    .DATA_W (outDataWidth),
    .KEEP_W (OUT_KEEP_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (int_rst_n),
    .load      (out_load),
    .load_data (merged_data),
    .load_keep (merged_keep),
    .load_last (S_AXIS_TLAST),
    .can_load  (can_load),
    .m_tdata   (M_AXIS_TDATA),
    .m_tkeep   (M_AXIS_TKEEP),
    .m_tlast   (M_AXIS_TLAST),
    .m_tvalid  (M_AXIS_TVALID),
    .m_tready  (M_AXIS_TREADY)
  );

  assign wordCount   = word_cnt_q;
  assign packetCount = pkt_cnt_q;
  assign keepError   = keep_err_q;

endmodule

// File: tb/tb_axis_input_packer.sv
module tb_axis_input_packer;

  localparam int unsigned IN_W  = 64;
  localparam int unsigned OUT_W = 128;
  localparam int unsigned CW    = 16;
  localparam int unsigned IK    = IN_W / 8;
  localparam int unsigned OK    = OUT_W / 8;
  localparam int unsigned RATIO = OUT_W / IN_W;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [IN_W-1:0] S_AXIS_TDATA = '0;
  logic [IK-1:0]   S_AXIS_TKEEP = '0;
  logic            S_AXIS_TLAST = 1'b0;
  logic            S_AXIS_TVALID = 1'b0;
  logic            S_AXIS_TREADY;
  logic [OUT_W-1:0] M_AXIS_TDATA;
  logic [OK-1:0]   M_AXIS_TKEEP;
  logic            M_AXIS_TLAST;
  logic            M_AXIS_TVALID;
  logic            M_AXIS_TREADY = 1'b0;
  logic [CW-1:0]   wordCount;
  logic [CW-1:0]   packetCount;
  logic            keepError;

  axis_input_packer #(
    .inDataWidth  (IN_W),
    .outDataWidth (OUT_W),
    .countWidth   (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TKEEP  (S_AXIS_TKEEP),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TKEEP  (M_AXIS_TKEEP),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .wordCount     (wordCount),
    .packetCount   (packetCount),
    .keepError     (keepError)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic [OK-1:0]    k;
    logic             l;
  } word_t;

  word_t           exp_q[$];
  logic [IN_W-1:0] pend_d[$];
  logic [IK-1:0]   pend_k[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_mode = 0;   // 0 always ready, 1 random, 2 low in [bp_lo,bp_hi], 3 never
  int bp_lo = 0;
  int bp_hi = 0;
  int stalls = 0;
  int words_seen = 0;
  int pkts_seen  = 0;
  bit armed = 1'b0;
  bit exp_kerr = 1'b0;

  task automatic chk(input string name, input logic [OUT_W-1:0] act,
                     input logic [OUT_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: gather accepted beats; a word is the concatenation of the
  // gathered beats (first in LSBs) once RATIO are held or TLAST arrives.
  task automatic model_accept(input logic [IN_W-1:0] d, input logic [IK-1:0] k,
                              input logic last);
    word_t w;
    pend_d.push_back(d);
    pend_k.push_back(k);
    if (!last && (k != {IK{1'b1}})) exp_kerr = 1'b1;
    if (last || (pend_d.size() == RATIO)) begin
      w.d = '0;
      w.k = '0;
      for (int i = 0; i < pend_d.size(); i++) begin
        w.d[i*IN_W +: IN_W] = pend_d[i];
        w.k[i*IK +: IK]     = pend_k[i];
      end
      w.l = last;
      exp_q.push_back(w);
      pend_d.delete();
      pend_k.delete();
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       M_AXIS_TREADY = 1'b1;
      1:       M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
      2:       M_AXIS_TREADY = !((cyc >= bp_lo) && (cyc <= bp_hi));
      default: M_AXIS_TREADY = 1'b0;
    endcase
  end

  // Monitor / scoreboard
  initial begin
    bit    hold_pend;
    word_t hold_w;
    word_t w;
    hold_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && armed) begin
        chk("s_ready_rule", S_AXIS_TREADY, !M_AXIS_TVALID || M_AXIS_TREADY);
        if (hold_pend) begin
          chk("hold_valid", M_AXIS_TVALID, 1'b1);
          chk("hold_data", M_AXIS_TDATA, hold_w.d);
          chk("hold_keep", M_AXIS_TKEEP, hold_w.k);
          chk("hold_last", M_AXIS_TLAST, hold_w.l);
        end
        hold_pend = M_AXIS_TVALID && !M_AXIS_TREADY;
        hold_w.d = M_AXIS_TDATA;
        hold_w.k = M_AXIS_TKEEP;
        hold_w.l = M_AXIS_TLAST;
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          chk("word_count", wordCount, CW'(words_seen));
          chk("packet_count", packetCount, CW'(pkts_seen));
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got 0x%0h want none", M_AXIS_TDATA);
          end else begin
            w = exp_q.pop_front();
            chk("out_data", M_AXIS_TDATA, w.d);
            chk("out_keep", M_AXIS_TKEEP, w.k);
            chk("out_last", M_AXIS_TLAST, w.l);
          end
          words_seen++;
          if (M_AXIS_TLAST) pkts_seen++;
        end
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    S_AXIS_TVALID = 1'b0;
    tick(n);
  endtask

  task automatic send_beat(input logic [IN_W-1:0] d, input logic [IK-1:0] k,
                           input logic last);
    bit acc;
    int waited;
    S_AXIS_TDATA  = d;
    S_AXIS_TKEEP  = k;
    S_AXIS_TLAST  = last;
    S_AXIS_TVALID = 1'b1;
    acc = 1'b0;
    waited = 0;
    while (!acc && (waited < 200)) begin
      @(negedge clk);
      if (S_AXIS_TREADY) acc = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
      waited++;
    end
    if (acc) model_accept(d, k, last);
    else chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    int t;
    S_AXIS_TVALID = 1'b0;
    t = 0;
    while (((exp_q.size() != 0) || M_AXIS_TVALID) && (t < 1000)) begin
      tick(1);
      t++;
    end
    chk("drain_timeout", (t < 1000), 1'b1);
  endtask

  task automatic do_reset();
    armed = 1'b0;
    rst = 1'b0;
    S_AXIS_TVALID = 1'b0;
    pend_d.delete();
    pend_k.delete();
    exp_q.delete();
    words_seen = 0;
    pkts_seen = 0;
    exp_kerr = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(4);
    armed = 1'b1;
  endtask

  function automatic logic [IN_W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    int stalls0;
    int c0;
    logic [CW-1:0] wc0;
    int len;
    logic [IK-1:0] k;

    // Reset state
    tick(3);
    chk("rst_tvalid", M_AXIS_TVALID, 1'b0);
    chk("rst_tdata", M_AXIS_TDATA, '0);
    chk("rst_tkeep", M_AXIS_TKEEP, '0);
    chk("rst_tlast", M_AXIS_TLAST, 1'b0);
    chk("rst_s_ready", S_AXIS_TREADY, 1'b0);
    chk("rst_wc", wordCount, '0);
    chk("rst_pc", packetCount, '0);
    chk("rst_kerr", keepError, 1'b0);
    do_reset();

    // Basic packing and latency
    send_beat(64'h1111111111111111, 8'hFF, 1'b0);
    chk("lat_before", M_AXIS_TVALID, 1'b0);
    send_beat(64'h2222222222222222, 8'hFF, 1'b1);
    chk("lat_after", M_AXIS_TVALID, 1'b1);
    chk("basic_data", M_AXIS_TDATA, 128'h2222222222222222_1111111111111111);
    chk("basic_keep", M_AXIS_TKEEP, 16'hFFFF);
    chk("basic_last", M_AXIS_TLAST, 1'b1);
    drain();
    tick(1);
    chk("basic_wc", wordCount, 16'd1);
    chk("basic_pc", packetCount, 16'd1);

    // Short packet
    send_beat(64'hAA, 8'h01, 1'b1);
    chk("short_data", M_AXIS_TDATA, 128'hAA);
    chk("short_keep", M_AXIS_TKEEP, 16'h0001);
    drain();
    chk("short_kerr", keepError, 1'b0);

    // Backpressure
    stalls0 = stalls;
    wc0 = wordCount;
    bp_lo = cyc + 3;
    bp_hi = cyc + 10;
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) send_beat(rnd64(), 8'hFF, (i == 7));
    drain();
    tick(1);
    chk("bp_stalled", (stalls > stalls0), 1'b1);
    chk("bp_wc", CW'(wordCount - wc0), 16'd4);
    rdy_mode = 0;
    tick(2);

    // Streaming
    stalls0 = stalls;
    wc0 = wordCount;
    c0 = cyc;
    for (int i = 0; i < 100; i++) send_beat(rnd64(), 8'hFF, (i == 99));
    chk("stream_cycles", cyc - c0, 100);
    chk("stream_stalls", stalls - stalls0, 0);
    drain();
    tick(1);
    chk("stream_wc", CW'(wordCount - wc0), 16'd50);

    // Keep error (sticky, data unchanged)
    send_beat(64'h0123456789ABCDEF, 8'h0F, 1'b0);
    send_beat(rnd64(), 8'hFF, 1'b1);
    drain();
    chk("kerr_set", keepError, exp_kerr);
    send_beat(rnd64(), 8'hFF, 1'b0);
    send_beat(rnd64(), 8'hFF, 1'b1);
    drain();
    chk("kerr_sticky", keepError, 1'b1);

    // Randomized packets with random backpressure and gaps
    rdy_mode = 1;
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        if (b == len - 1) k = IK'($urandom());
        else if ($urandom_range(0, 7) == 0) k = IK'($urandom());
        else k = '1;
        send_beat(rnd64(), k, (b == len - 1));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    rdy_mode = 0;
    drain();
    chk("rand_kerr", keepError, exp_kerr);

    // Async reset with a held output word and a pending input beat
    rdy_mode = 3;
    tick(2);
    send_beat(rnd64(), 8'hFF, 1'b0);
    send_beat(rnd64(), 8'hFF, 1'b0);
    tick(2);
    chk("pre_rst_valid", M_AXIS_TVALID, 1'b1);
    S_AXIS_TDATA  = rnd64();
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TVALID = 1'b1;
    #1;
    armed = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_tvalid", M_AXIS_TVALID, 1'b0);
    chk("async_tdata", M_AXIS_TDATA, '0);
    chk("async_s_ready", S_AXIS_TREADY, 1'b0);
    chk("async_wc", wordCount, '0);
    rdy_mode = 0;
    do_reset();

    // Reset mid-assembly: stale lane-0 beat must not survive
    send_beat(64'hDEADBEEFDEADBEEF, 8'hFF, 1'b0);
    do_reset();
    send_beat(64'h3333333333333333, 8'hFF, 1'b0);
    send_beat(64'h4444444444444444, 8'hFF, 1'b1);
    chk("post_rst_data", M_AXIS_TDATA, 128'h4444444444444444_3333333333333333);
    drain();
    chk("post_rst_kerr", keepError, 1'b0);
    chk("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
